// File: rtl/maxpool_pkg.sv
// Shared constants and state encoding for the max-pooling controller.
package maxpool_pkg;

    localparam int DATA_W_DEF  = 22;
    localparam int IMG_DIM_DEF = 8;
    localparam int WIN_DIM_DEF = 4;
    localparam int NUM_WIN     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_POOL,
        ST_WRITE,
        ST_FINISH
    } state_e;

endpackage

// File: rtl/maxpool_addr_gen.sv
// Maps window index w and in-window slot k to a row-major image address.
module maxpool_addr_gen
    import maxpool_pkg::*;
(
    input  logic [$clog2(NUM_WIN)-1:0] w_i,
    input  logic [3:0]                 k_i,
    output logic [5:0]                 addr_o
);

    // row = {w[1], k[3:2]}, col = {w[0], k[1:0]} on an 8-wide image
    assign addr_o = {w_i[1], k_i[3:2], w_i[0], k_i[1:0]};

endmodule

// File: rtl/maxpool_controller.sv
// Fetches each 4x4 window, hands it to the pooling datapath, writes the result.
module maxpool_controller
    import maxpool_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int IMG_DIM = IMG_DIM_DEF,
    parameter int WIN_DIM = WIN_DIM_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [5:0]           mem_addr,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [16*DATA_W-1:0] pool_window,
    output logic                 pool_enable,
    input  logic                 pool_done,
    input  logic [DATA_W-1:0]    pool_result,
    output logic                 res_wr_en,
    output logic [1:0]           res_addr,
    output logic [DATA_W-1:0]    res_wdata
);

    localparam int NWIN  = (IMG_DIM / WIN_DIM) * (IMG_DIM / WIN_DIM);
    localparam int NSLOT = WIN_DIM * WIN_DIM;

    state_e                state_q, state_d;
    logic [1:0]            w_q, w_d;
    logic [4:0]            k_q, k_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  rd_en_q, rd_en_d;
    logic [5:0]            addr_q, addr_d;
    logic                  pe_q, pe_d;
    logic [16*DATA_W-1:0]  win_q, win_d;
    logic                  wr_en_q, wr_en_d;
    logic [1:0]            res_addr_q, res_addr_d;
    logic [DATA_W-1:0]     res_wdata_q, res_wdata_d;
    logic [5:0]            gen_addr;

    maxpool_addr_gen u_addr_gen (
        .w_i    (w_d),
        .k_i    (k_d[3:0]),
        .addr_o (gen_addr)
    );

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        k_d         = k_q;
        win_d       = win_q;
        res_addr_d  = res_addr_q;
        res_wdata_d = res_wdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    w_d     = '0;
                    k_d     = '0;
                end
            end
            ST_FETCH: begin
                // read k-1 returns now
                if (k_q != '0)
                    win_d[(int'(k_q) - 1) * DATA_W +: DATA_W] = mem_rdata;
                if (k_q == 5'(NSLOT))
                    state_d = ST_POOL;
                else
                    k_d = k_q + 5'd1;
            end
            ST_POOL: begin
                if (pool_done) begin
                    res_wdata_d = pool_result;
                    res_addr_d  = w_q;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_q == 2'(NWIN - 1)) begin
                    state_d = ST_FINISH;
                end else begin
                    w_d     = w_q + 2'd1;
                    k_d     = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            w_d         = '0;
            k_d         = '0;
            win_d       = win_q;
            res_addr_d  = res_addr_q;
            res_wdata_d = res_wdata_q;
        end
    end

    // outputs decoded from next state so they are registered with it
    always_comb begin
        rd_en_d = (state_d == ST_FETCH) && (k_d < 5'(NSLOT));
        addr_d  = rd_en_d ? gen_addr : '0;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FINISH);
        pe_d    = (state_d == ST_POOL);
        wr_en_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            pe_q        <= 1'b0;
            win_q       <= '0;
            wr_en_q     <= 1'b0;
            res_addr_q  <= '0;
            res_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            pe_q        <= pe_d;
            win_q       <= win_d;
            wr_en_q     <= wr_en_d;
            res_addr_q  <= res_addr_d;
            res_wdata_q <= res_wdata_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = rd_en_q;
    assign mem_addr    = addr_q;
    assign pool_enable = pe_q;
    assign pool_window = win_q;
    assign res_wr_en   = wr_en_q;
    assign res_addr    = res_addr_q;
    assign res_wdata   = res_wdata_q;

endmodule

// File: tb/tb_maxpool_controller.sv
// Directed-random bench for maxpool_controller with memory and pooling models.
module tb_maxpool_controller;

    localparam int DW = 22;

    logic              clk = 1'b0;
    logic              reset_n, start, abort;
    logic              busy, done, mem_rd_en, pool_enable, pool_done, res_wr_en;
    logic [5:0]        mem_addr;
    logic [DW-1:0]     mem_rdata, pool_result, res_wdata;
    logic [16*DW-1:0]  pool_window;
    logic [1:0]        res_addr;

    always #5 clk = ~clk;

    maxpool_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pool_window (pool_window),
        .pool_enable (pool_enable),
        .pool_done   (pool_done),
        .pool_result (pool_result),
        .res_wr_en   (res_wr_en),
        .res_addr    (res_addr),
        .res_wdata   (res_wdata)
    );

    logic [DW-1:0] mem [64];
    int   lat = 3;
    logic tie_hi = 1'b0;
    int   pcnt = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    // image memory: one-cycle read latency, garbage when not reading
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pcnt <= pool_enable ? pcnt + 1 : 0;
        mem_rdata <= mem_rd_en ? mem[mem_addr] : DW'($urandom);
    end

    assign pool_done = tie_hi | (pool_enable && pcnt >= lat);

    always_comb begin
        pool_result = '0;
        for (int k = 0; k < 16; k++)
            if (pool_window[k*DW +: DW] > pool_result)
                pool_result = pool_window[k*DW +: DW];
    end

    int            rd_log[$];
    logic [1:0]    wa_log[$];
    logic [DW-1:0] wd_log[$];
    int            done_cnt = 0, done_cyc = 0;
    int            win_chg = 0, pe_run = 0, pe_max = 0;
    logic          pe_prev = 1'b0;
    logic [16*DW-1:0] win_snap;

    always @(negedge clk) begin
        if (mem_rd_en) rd_log.push_back(int'(mem_addr));
        if (res_wr_en) begin
            wa_log.push_back(res_addr);
            wd_log.push_back(res_wdata);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (pool_enable) begin
            if (!pe_prev) begin
                win_snap = pool_window;
                pe_run = 0;
            end
            pe_run++;
            if (pe_run > pe_max) pe_max = pe_run;
            if (pool_window !== win_snap) win_chg++;
        end
        pe_prev = pool_enable;
    end

    function automatic int ref_addr(int w, int k);
        int row, col;
        row = (w / 2) * 4 + k / 4;
        col = (w % 2) * 4 + k % 4;
        return row * 8 + col;
    endfunction

    function automatic logic [DW-1:0] ref_max(int w);
        logic [DW-1:0] m = '0;
        for (int k = 0; k < 16; k++)
            if (mem[ref_addr(w, k)] > m) m = mem[ref_addr(w, k)];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        @(posedge clk);
        #1;
        rd_log.delete();
        wa_log.delete();
        wd_log.delete();
        done_cnt = 0;
        win_chg = 0;
        pe_max = 0;
    endtask

    task automatic fill_mem(input bit by_addr);
        for (int i = 0; i < 64; i++)
            mem[i] = by_addr ? DW'(i) : DW'($urandom);
    endtask

    task automatic start_pass(output int se);
        @(negedge clk);
        start = 1'b1;
        se = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        int n = 0;
        while (cyc < target && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic verify_pass(input string tag);
        int bad = 0;
        chk({tag, "_nwr"}, 64'(wa_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < wa_log.size(); i++) begin
            chk({tag, "_wr_addr"}, 64'(wa_log[i]), 64'(i));
            chk({tag, "_wr_data"}, 64'(wd_log[i]), 64'(ref_max(i)));
        end
        chk({tag, "_nrd"}, 64'(rd_log.size()), 64'd64);
        for (int i = 0; i < 64 && i < rd_log.size(); i++)
            if (rd_log[i] != ref_addr(i / 16, i % 16)) bad++;
        chk({tag, "_rd_seq"}, 64'(bad), 64'd0);
        chk({tag, "_ndone"}, 64'(done_cnt), 64'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_pe"}, 64'(pool_enable), 64'd0);
        chk({tag, "_win"}, 64'(pool_window != '0), 64'd0);
        chk({tag, "_wr_en"}, 64'(res_wr_en), 64'd0);
        chk({tag, "_res_addr"}, 64'(res_addr), 64'd0);
        chk({tag, "_res_wdata"}, 64'(res_wdata), 64'd0);
    endtask

    initial begin
        int se;
        int n;
        logic [DW-1:0] exp_id [4];
        exp_id[0] = 27;
        exp_id[1] = 31;
        exp_id[2] = 59;
        exp_id[3] = 63;

        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst");
        reset_n = 1'b1;

        // identity image: known maxima
        lat = 3;
        tie_hi = 1'b0;
        clear_logs();
        start_pass(se);
        wait_done(400, "ident");
        verify_pass("ident");
        for (int i = 0; i < 4 && i < wd_log.size(); i++)
            chk("ident_const", 64'(wd_log[i]), 64'(exp_id[i]));

        // pool_done tied high: cycle-exact completion
        fill_mem(1'b0);
        tie_hi = 1'b1;
        clear_logs();
        start_pass(se);
        wait_done(200, "tie");
        chk("tie_done_cyc", 64'(done_cyc - se), 64'd76);
        chk("tie_pool_len", 64'(pe_max), 64'd1);
        verify_pass("tie");

        // start re-pulsed during fetch of window 1
        fill_mem(1'b0);
        tie_hi = 1'b0;
        lat = 2;
        clear_logs();
        start_pass(se);
        wait_until(se + 25);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, "restart");
        verify_pass("restart");
        repeat (5) @(negedge clk);
        chk("restart_idle", 64'(busy), 64'd0);

        // abort during fetch of window 2
        fill_mem(1'b0);
        tie_hi = 1'b1;
        clear_logs();
        start_pass(se);
        wait_until(se + 42);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
        repeat (30) @(negedge clk);
        chk("abort_nwr", 64'(wa_log.size()), 64'd2);
        if (wa_log.size() >= 2) begin
            chk("abort_wa0", 64'(wa_log[0]), 64'd0);
            chk("abort_wa1", 64'(wa_log[1]), 64'd1);
        end
        chk("abort_ndone", 64'(done_cnt), 64'd0);

        fill_mem(1'b0);
        tie_hi = 1'b0;
        lat = 1;
        clear_logs();
        start_pass(se);
        wait_done(300, "post_abort");
        verify_pass("post_abort");

        // reset during pool of window 1
        fill_mem(1'b0);
        lat = 5;
        clear_logs();
        start_pass(se);
        n = 0;
        while (!(pool_enable && wa_log.size() == 1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reached", 64'(pool_enable), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outs("mid_rst");
        repeat (60) @(negedge clk);
        chk("mid_rst_nwr", 64'(wa_log.size()), 64'd1);
        chk("mid_rst_ndone", 64'(done_cnt), 64'd0);
        chk("mid_rst_idle", 64'(busy), 64'd0);

        // slow datapath on every window
        fill_mem(1'b0);
        lat = 100;
        clear_logs();
        start_pass(se);
        wait_done(1000, "slow");
        verify_pass("slow");
        chk("slow_pool_len", 64'(pe_max), 64'd101);
        chk("slow_win_stable", 64'(win_chg), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
